multi_pattern_pwm: RTL

Multi-channel pattern PWM generator: `CH_NUM` independent channels, each serialising its own bit pattern LSB-first with a programmable bit time, inter-frame gap and repetition count. It succeeds the single-channel pattern PWM in the DDS sample-generation path. It adds per-channel configuration, synchronous multi-channel start, global abort, and a per-channel and aggregate completion report.

---
 rtl/multi_pattern_pwm.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_pattern_pwm.sv
// multi_pattern_pwm
//   CH_NUM independent pattern PWM channels. Each channel serialises its own
//   pattern LSB-first, holding every bit for bit_len+1 cycles, inserting
//   gap_len idle cycles between frames and repeating rep_num frames
//   (rep_num = 0 runs until stop). The frame length is set by the highest
//   set bit of the pattern.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle launch strobe, qualified per channel by ch_en
//   stop         one-cycle global abort; wins over a simultaneous start
//   ch_en        channel select applied to start
//   pat          per-channel patterns      [c*PAT_WIDTH +: PAT_WIDTH]
//   bit_len      per-channel cycles per bit minus 1
//   gap_len      per-channel idle cycles between frames
//   rep_num      per-channel frame count (0 = infinite)
//   out_pol      per-channel output polarity (only with the macro below)
//   pwm_out      channel outputs (registered)
//   busy         channel active
//   done         one-cycle pulse on every busy->idle transition
//   all_done     one-cycle pulse when the last busy channel goes idle
//
// Build option
//   MULTI_PATTERN_PWM_POL_EN  adds out_pol; output = pattern bit XOR out_pol,
//                             idle level = out_pol (live while idle).

module multi_pattern_pwm_ch #(
    parameter int PAT_WIDTH = 16,
    parameter int BIT_W     = 8,
    parameter int GAP_W     = 16,
    parameter int REP_W     = 8,
    parameter int IDX_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 launch,
    input  logic                 abort,
    input  logic                 pol,
    input  logic [PAT_WIDTH-1:0] pat,
    input  logic [BIT_W-1:0]     bit_len,
    input  logic [GAP_W-1:0]     gap_len,
    input  logic [REP_W-1:0]     rep_num,
    output logic                 pwm,
    output logic                 busy,
    output logic                 done,
    output logic                 busy_nxt
);

    typedef enum logic [1:0] {S_IDLE, S_BIT, S_GAP} state_t;

    state_t               state_q, state_d;
    logic [PAT_WIDTH-1:0] pat_q, pat_d;
    logic [BIT_W-1:0]     bl_q, bl_d, bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]     gl_q, gl_d, gap_cnt_q, gap_cnt_d;
    logic [REP_W-1:0]     rep_q, rep_d, frame_q, frame_d;
    logic [IDX_W-1:0]     last_q, last_d, idx_q, idx_d;
    logic                 pol_q, pol_d;
    logic                 pwm_q, pwm_d, busy_q, busy_d, done_q, done_d;

    logic [IDX_W-1:0]     last_idx;
    logic [IDX_W-1:0]     idx_inc;

    // Index of the highest set bit of the incoming pattern.
    always_comb begin
        last_idx = '0;
        for (int i = 0; i < PAT_WIDTH; i++) begin
            if (pat[i]) last_idx = IDX_W'(i);
        end
    end

    assign idx_inc = idx_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        bl_d      = bl_q;
        gl_d      = gl_q;
        rep_d     = rep_q;
        last_d    = last_q;
        pol_d     = pol_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        idx_d     = idx_q;
        frame_d   = frame_q;
        pwm_d     = pwm_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                pwm_d = pol;
                if (launch && (|pat)) begin
                    state_d   = S_BIT;
                    pat_d     = pat;
                    bl_d      = bit_len;
                    gl_d      = gap_len;
                    rep_d     = rep_num;
                    last_d    = last_idx;
                    pol_d     = pol;
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    frame_d   = '0;
                    busy_d    = 1'b1;
                    pwm_d     = pat[0] ^ pol;
                end
            end
            S_BIT: begin
                if (bit_cnt_q != bl_q) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else begin
                    bit_cnt_d = '0;
                    if (idx_q != last_q) begin
                        idx_d = idx_inc;
                        pwm_d = pat_q[idx_inc] ^ pol_q;
                    end else if ((rep_q != '0) && (frame_q == rep_q - 1'b1)) begin
                        // final frame: no trailing gap
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pwm_d   = pol;
                    end else begin
                        // infinite mode holds the frame counter so it never wraps
                        if (rep_q != '0) frame_d = frame_q + 1'b1;
                        idx_d = '0;
                        if (gl_q == '0) begin
                            pwm_d = pat_q[0] ^ pol_q;
                        end else begin
                            state_d   = S_GAP;
                            gap_cnt_d = '0;
                            pwm_d     = pol_q;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == gl_q - 1'b1) begin
                    state_d   = S_BIT;
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    pwm_d     = pat_q[0] ^ pol_q;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && busy_q) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pwm_d   = pol;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            bl_q      <= '0;
            gl_q      <= '0;
            rep_q     <= '0;
            last_q    <= '0;
            pol_q     <= 1'b0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            idx_q     <= '0;
            frame_q   <= '0;
            pwm_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            bl_q      <= bl_d;
            gl_q      <= gl_d;
            rep_q     <= rep_d;
            last_q    <= last_d;
            pol_q     <= pol_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            pwm_q     <= pwm_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign pwm      = pwm_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign busy_nxt = busy_d;

endmodule

module multi_pattern_pwm #(
    parameter int CH_NUM    = 4,
    parameter int PAT_WIDTH = 16,
    parameter int BIT_W     = 8,
    parameter int GAP_W     = 16,
    parameter int REP_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          stop,
    input  logic [CH_NUM-1:0]             ch_en,
    input  logic [CH_NUM*PAT_WIDTH-1:0]   pat,
    input  logic [CH_NUM*BIT_W-1:0]       bit_len,
    input  logic [CH_NUM*GAP_W-1:0]       gap_len,
    input  logic [CH_NUM*REP_W-1:0]       rep_num,
`ifdef MULTI_PATTERN_PWM_POL_EN
    input  logic [CH_NUM-1:0]             out_pol,
`endif
    output logic [CH_NUM-1:0]             pwm_out,
    output logic [CH_NUM-1:0]             busy,
    output logic [CH_NUM-1:0]             done,
    output logic                          all_done
);

    localparam int IDX_W = (PAT_WIDTH > 1) ? $clog2(PAT_WIDTH) : 1;

    logic [CH_NUM-1:0] pol;
    logic [CH_NUM-1:0] busy_nxt;
    logic [CH_NUM-1:0] launch;
    logic              all_done_q, all_done_d;

`ifdef MULTI_PATTERN_PWM_POL_EN
    assign pol = out_pol;
`else
    assign pol = '0;
`endif

    // stop wins: nothing launches in an abort cycle
    assign launch = (start && !stop) ? ch_en : '0;

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        multi_pattern_pwm_ch #(
            .PAT_WIDTH (PAT_WIDTH),
            .BIT_W     (BIT_W),
            .GAP_W     (GAP_W),
            .REP_W     (REP_W),
            .IDX_W     (IDX_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .launch   (launch[c]),
            .abort    (stop),
            .pol      (pol[c]),
            .pat      (pat[c*PAT_WIDTH +: PAT_WIDTH]),
            .bit_len  (bit_len[c*BIT_W +: BIT_W]),
            .gap_len  (gap_len[c*GAP_W +: GAP_W]),
            .rep_num  (rep_num[c*REP_W +: REP_W]),
            .pwm      (pwm_out[c]),
            .busy     (busy[c]),
            .done     (done[c]),
            .busy_nxt (busy_nxt[c])
        );
    end

    // Registered alongside busy so the pulse lands on the same edge busy clears.
    always_comb all_done_d = (|busy) && !(|busy_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) all_done_q <= 1'b0;
        else        all_done_q <= all_done_d;
    end

    assign all_done = all_done_q;

endmodule
